// File: rtl/seg7_digit_driver.sv
// seg7_digit_driver: scan-aligned 7-segment cathode driver for a 4-digit
// display. A shadow register takes host writes at any time. The shown value
// (active) only changes at frame end, so a frame never mixes old and new
// digits. Each digit lane decodes its own nibble and works out its own blanking.
// A single output register keeps seg/dp aligned with the anode pattern.

module seg7_digit_lane (
  input  logic [3:0] nib,
  input  logic       blank,
  input  logic       dp_req,
  output logic [6:0] seg,
  output logic       dp
);

  logic [6:0] hex;

  // Hex to active-low {g..a}; a blanked lane is fully dark, dp included
  always_comb begin
    hex = 7'h7F;
    case (nib)
      4'h0: hex = 7'h40;
      4'h1: hex = 7'h79;
      4'h2: hex = 7'h24;
      4'h3: hex = 7'h30;
      4'h4: hex = 7'h19;
      4'h5: hex = 7'h12;
      4'h6: hex = 7'h02;
      4'h7: hex = 7'h78;
      4'h8: hex = 7'h00;
      4'h9: hex = 7'h10;
      4'hA: hex = 7'h08;
      4'hB: hex = 7'h03;
      4'hC: hex = 7'h46;
      4'hD: hex = 7'h21;
      4'hE: hex = 7'h06;
      4'hF: hex = 7'h0E;
      default: hex = 7'h7F;
    endcase
    seg = blank ? 7'h7F : hex;
    dp  = blank | ~dp_req;
  end

endmodule

module seg7_digit_driver #(
  parameter int BLINK_W = 6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ce,
  input  logic [1:0]  q,
  input  logic [3:0]  an_in,
  input  logic [15:0] din,
  input  logic [3:0]  dp_in,
  input  logic        load,
  input  logic        blank_lz,
  input  logic [3:0]  blink_en,
  output logic [6:0]  seg,
  output logic        dp,
  output logic [3:0]  an,
  output logic        pending
);

  localparam int NUM_DIG = 4;

  logic [15:0]              shadow;
  logic [NUM_DIG-1:0][3:0]  active;
  logic [BLINK_W-1:0]       frame_cnt;
  logic                     frame_end;
  logic                     blink_ph;

  logic [NUM_DIG-1:0]       zero_up;    // this nibble and all above are zero
  logic [NUM_DIG-1:0]       lane_blank;
  logic [NUM_DIG-1:0][6:0]  lane_seg;
  logic [NUM_DIG-1:0]       lane_dp;

  assign frame_end = ce && (q == 2'd3);
  assign blink_ph  = frame_cnt[BLINK_W-1];

  // Shadow capture, frame-boundary transfer and frame counting.
  // A load coinciding with frame end goes straight to active.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow    <= '0;
      active    <= '0;
      pending   <= 1'b0;
      frame_cnt <= '0;
    end else begin
      if (load) shadow <= din;
      if (frame_end) begin
        frame_cnt <= frame_cnt + BLINK_W'(1);
        if (pending || load) active <= load ? din : shadow;
        pending <= 1'b0;
      end else if (load) begin
        pending <= 1'b1;
      end
    end
  end

  for (genvar g = 0; g < NUM_DIG; g++) begin : g_lane
    assign zero_up[g] = ((active >> (4 * g)) == 16'h0);

    // Digit 0 is never leading-zero blanked, so a value of 0 still shows "0"
    if (g == 0) begin : g_lsd
      assign lane_blank[g] = blink_en[g] && blink_ph;
    end else begin : g_upper
      assign lane_blank[g] = (blank_lz && zero_up[g]) || (blink_en[g] && blink_ph);
    end

    seg7_digit_lane u_lane (
      .nib    (active[g]),
      .blank  (lane_blank[g]),
      .dp_req (dp_in[g]),
      .seg    (lane_seg[g]),
      .dp     (lane_dp[g])
    );
  end

  // Single output stage, clocked every cycle: an, seg and dp stay aligned
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seg <= 7'h7F;
      dp  <= 1'b1;
      an  <= 4'hF;
    end else begin
      seg <= lane_seg[q];
      dp  <= lane_dp[q];
      an  <= an_in;
    end
  end

endmodule

// File: tb/tb_seg7_digit_driver.sv
// Directed bench for seg7_digit_driver (BLINK_W=2): reset, load/transfer,
// leading-zero blanking, load at frame end, ce gating, anode pass-through,
// blink and frame counter wrap.

module tb_seg7_digit_driver;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        ce = 1'b0;
  logic [1:0]  q = 2'd0;
  logic [3:0]  an_in = 4'hF;
  logic [15:0] din = 16'h0;
  logic [3:0]  dp_in = 4'h0;
  logic        load = 1'b0;
  logic        blank_lz = 1'b0;
  logic [3:0]  blink_en = 4'h0;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  an;
  logic        pending;

  int n_cmp = 0;
  int n_err = 0;

  seg7_digit_driver #(.BLINK_W(2)) dut (
    .clk      (clk),
    .rst      (rst),
    .ce       (ce),
    .q        (q),
    .an_in    (an_in),
    .din      (din),
    .dp_in    (dp_in),
    .load     (load),
    .blank_lz (blank_lz),
    .blink_en (blink_en),
    .seg      (seg),
    .dp       (dp),
    .an       (an),
    .pending  (pending)
  );

  always #5 clk = ~clk;

  // One scan cycle: present q/an/ce/load, clock, settle 1 time unit past the edge
  task automatic drive(input logic [1:0] qq, input logic cc, input logic ld);
    q     = qq;
    an_in = ~(4'b0001 << qq);
    ce    = cc;
    load  = ld;
    @(posedge clk);
    #1;
    load = 1'b0;
    ce   = 1'b0;
  endtask

  task automatic test_reset;
    #1 rst = 1'b1;
    #1;
    n_cmp++;
    if (seg !== 7'h7F || dp !== 1'b1 || an !== 4'hF || pending !== 1'b0) begin
      n_err++;
      $display("FAIL reset_init: seg=%h dp=%b an=%h pend=%b want 7f 1 f 0", seg, dp, an, pending);
    end
    rst = 1'b0;
    @(posedge clk); #1;
    // Put some activity up, then reset mid-frame between clock edges
    din = 16'h8888;
    drive(0, 1, 1); drive(1, 1, 0); drive(2, 1, 0); drive(3, 1, 0);
    drive(0, 1, 1);
    n_cmp++;
    if (seg !== 7'h00 || pending !== 1'b1) begin
      n_err++;
      $display("FAIL reset_preact: seg=%h pend=%b want 00 1", seg, pending);
    end
    #2 rst = 1'b1;
    #1;
    n_cmp++;
    if (seg !== 7'h7F || dp !== 1'b1 || an !== 4'hF || pending !== 1'b0) begin
      n_err++;
      $display("FAIL reset_async: seg=%h dp=%b an=%h pend=%b want 7f 1 f 0", seg, dp, an, pending);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    // After release the display shows 0 on every digit (no LZ blanking)
    for (int i = 0; i < 4; i++) begin
      drive(2'(i), 1, 0);
      n_cmp++;
      if (seg !== 7'h40 || dp !== 1'b1) begin
        n_err++;
        $display("FAIL reset_zero q%0d: seg=%h dp=%b want 40 1", i, seg, dp);
      end
    end
  endtask

  task automatic test_load_transfer;
    logic [6:0] exp_seg [4] = '{7'h0E, 7'h08, 7'h24, 7'h79};
    din = 16'h12AF;
    drive(0, 1, 0);
    drive(1, 1, 1);
    n_cmp++;
    if (pending !== 1'b1 || seg !== 7'h40) begin
      n_err++;
      $display("FAIL load_pend: pend=%b seg=%h want 1 40", pending, seg);
    end
    drive(2, 1, 0);
    n_cmp++;
    if (seg !== 7'h40) begin
      n_err++;
      $display("FAIL load_unchanged: seg=%h want 40", seg);
    end
    drive(3, 1, 0);
    n_cmp++;
    if (pending !== 1'b0) begin
      n_err++;
      $display("FAIL load_xfer_pend: pend=%b want 0", pending);
    end
    for (int i = 0; i < 4; i++) begin
      drive(2'(i), 1, 0);
      n_cmp++;
      if (seg !== exp_seg[i] || an !== ~(4'b0001 << i) || dp !== 1'b1) begin
        n_err++;
        $display("FAIL load_show q%0d: seg=%h an=%h dp=%b want %h %h 1",
                 i, seg, an, dp, exp_seg[i], ~(4'b0001 << i));
      end
    end
  endtask

  task automatic test_lz;
    logic [15:0] f_din [5] = '{16'h0005, 16'h0000, 16'h0100, 16'h0000, 16'h0000};
    logic        f_ld  [5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    logic        f_blz [5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    logic [3:0]  f_dp  [5] = '{4'h0, 4'hF, 4'h0, 4'h0, 4'h0};
    logic [6:0]  f_seg [5][4] = '{
      '{7'h0E, 7'h08, 7'h24, 7'h79},   // 12AF, no blanking
      '{7'h12, 7'h7F, 7'h7F, 7'h7F},   // 0005 blanked, dp requested on all
      '{7'h40, 7'h7F, 7'h7F, 7'h7F},   // 0000 blanked
      '{7'h40, 7'h40, 7'h79, 7'h7F},   // 0100 blanked
      '{7'h40, 7'h40, 7'h79, 7'h40}};  // 0100 unblanked
    logic        f_dpx [5][4] = '{
      '{1'b1, 1'b1, 1'b1, 1'b1},
      '{1'b0, 1'b1, 1'b1, 1'b1},
      '{1'b1, 1'b1, 1'b1, 1'b1},
      '{1'b1, 1'b1, 1'b1, 1'b1},
      '{1'b1, 1'b1, 1'b1, 1'b1}};
    for (int f = 0; f < 5; f++) begin
      din = f_din[f]; blank_lz = f_blz[f]; dp_in = f_dp[f];
      for (int i = 0; i < 4; i++) begin
        drive(2'(i), 1, (i == 0) ? f_ld[f] : 1'b0);
        n_cmp++;
        if (seg !== f_seg[f][i] || dp !== f_dpx[f][i]) begin
          n_err++;
          $display("FAIL lz f%0d q%0d: seg=%h dp=%b want %h %b",
                   f, i, seg, dp, f_seg[f][i], f_dpx[f][i]);
        end
      end
    end
    blank_lz = 1'b0; dp_in = 4'h0;
  endtask

  task automatic test_simul;
    din = 16'hBEEF;
    drive(0, 1, 0);
    drive(1, 1, 1);
    n_cmp++;
    if (pending !== 1'b1) begin
      n_err++;
      $display("FAIL simul_pend: pend=%b want 1", pending);
    end
    drive(2, 1, 0);
    din = 16'h3333;
    drive(3, 1, 1);
    n_cmp++;
    if (pending !== 1'b0) begin
      n_err++;
      $display("FAIL simul_pend0: pend=%b want 0", pending);
    end
    for (int f = 0; f < 2; f++) begin
      for (int i = 0; i < 4; i++) begin
        drive(2'(i), 1, 0);
        n_cmp++;
        if (seg !== 7'h30) begin
          n_err++;
          $display("FAIL simul_show f%0d q%0d: seg=%h want 30", f, i, seg);
        end
      end
    end
  endtask

  task automatic test_ce_gate;
    din = 16'h4444;
    drive(0, 1, 1); drive(1, 1, 0); drive(2, 1, 0);
    drive(3, 0, 0);
    n_cmp++;
    if (pending !== 1'b1) begin
      n_err++;
      $display("FAIL ce_gate_pend: pend=%b want 1", pending);
    end
    drive(0, 1, 0);
    n_cmp++;
    if (seg !== 7'h30) begin
      n_err++;
      $display("FAIL ce_gate_hold: seg=%h want 30", seg);
    end
    drive(1, 1, 0); drive(2, 1, 0); drive(3, 1, 0);
    drive(0, 1, 0);
    n_cmp++;
    if (seg !== 7'h19 || pending !== 1'b0) begin
      n_err++;
      $display("FAIL ce_gate_xfer: seg=%h pend=%b want 19 0", seg, pending);
    end
  endtask

  task automatic test_anode;
    q = 2'd1; an_in = 4'b0000; ce = 1'b0;
    @(posedge clk); #1;
    n_cmp++;
    if (an !== 4'b0000 || seg !== 7'h19) begin
      n_err++;
      $display("FAIL anode_pass: an=%h seg=%h want 0 19", an, seg);
    end
    an_in = 4'b1010;
    @(posedge clk); #1;
    n_cmp++;
    if (an !== 4'b1010) begin
      n_err++;
      $display("FAIL anode_pass2: an=%h want a", an);
    end
  endtask

  task automatic test_blink;
    // Frame counter starts at 0 after reset; MSB of a 2-bit counter: lit,lit,dark,dark,lit,lit
    logic lit [6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    logic [6:0] e_seg;
    logic       e_dp;
    rst = 1'b1; #2; rst = 1'b0;
    @(posedge clk); #1;
    blink_en = 4'b0001; dp_in = 4'b0001;
    for (int f = 0; f < 6; f++) begin
      for (int s = 0; s < 5; s++) begin
        // extra ce=0 visit at q=3 must not advance the frame counter
        drive((s < 3) ? 2'(s) : 2'd3, (s != 3), 0);
        e_seg = (s == 0 && !lit[f]) ? 7'h7F : 7'h40;
        e_dp  = (s == 0) ? !lit[f] : 1'b1;
        n_cmp++;
        if (seg !== e_seg || dp !== e_dp) begin
          n_err++;
          $display("FAIL blink f%0d s%0d: seg=%h dp=%b want %h %b", f, s, seg, dp, e_seg, e_dp);
        end
      end
    end
    blink_en = 4'h0; dp_in = 4'h0;
  endtask

  initial begin
    test_reset;
    test_load_transfer;
    test_lz;
    test_simul;
    test_ce_gate;
    test_anode;
    test_blink;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
